// File: rtl/alu_calc_pkg.sv
// Shared encodings for the calculator arithmetic engine: op codes, error codes, FSM states.
package alu_calc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_FACT = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, DIV, FACT} state_t;

endpackage

// File: rtl/impartire_secv.sv
// Unsigned restoring divider, one quotient bit per cycle for W cycles.
// The outputs present the step being computed this cycle; done flags the
// final step, so the caller can register the finished result on that edge.
module impartire_secv #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  q_reg;      // dividend bits shift out as quotient bits shift in
  logic [W-1:0]  r_reg;
  logic [W-1:0]  d_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          fits;

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    trial     = {r_reg, q_reg[W-1]};
    diff      = trial - {1'b0, d_reg};
    fits      = ~diff[W];
    remainder = fits ? diff[W-1:0] : trial[W-1:0];
    quotient  = {q_reg[W-2:0], fits};
    done      = busy_reg && (cnt_reg == CW'(W - 1));
  end

  // Load operands on start, then advance one step per cycle until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      q_reg    <= dividend;
      r_reg    <= '0;
      d_reg    <= divisor;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      q_reg   <= quotient;
      r_reg   <= remainder;
      cnt_reg <= cnt_reg + CW'(1);
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_calc.sv
// Multi-mode signed arithmetic engine: ADD/SUB/MUL resolve at acceptance,
// DIV/MOD use the sequential divider, FACT multiplies one factor per cycle.
module alu_calc
  import alu_calc_pkg::*;
#(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic         ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  output logic         valid_out,
  output logic [W-1:0] d_out,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  state_t state_reg, state_next;
  logic         mod_reg, mod_next;
  logic         neg_q_reg, neg_q_next;
  logic         neg_r_reg, neg_r_next;
  logic [W-1:0] acc_reg, acc_next;
  logic [W-1:0] idx_reg, idx_next;
  logic [W-1:0] lim_reg, lim_next;
  logic         valid_next, err_next;
  logic [W-1:0] d_next;
  logic [1:0]   code_next;

  logic [W-1:0]        sum, diff, mag1, mag2, quo, rem;
  logic                add_ovf, sub_ovf, div_start, div_done;
  logic signed [W-1:0] mul_a, mul_b;
  logic signed [2*W-1:0] product;
  logic [W:0]          prod_top;
  logic                mul_ovf;
  logic                fin, fin_err;
  logic [1:0]          fin_code;
  logic [W-1:0]        fin_val;

  assign ready = (state_reg == IDLE);

  // Shared datapath: add/sub with sign-rule overflow, one muxed 2W-bit multiplier.
  always_comb begin
    sum      = n1 + n2;
    diff     = n1 - n2;
    add_ovf  = (n1[W-1] == n2[W-1]) && (sum[W-1] != n1[W-1]);
    sub_ovf  = (n1[W-1] != n2[W-1]) && (diff[W-1] != n1[W-1]);
    mag1     = n1[W-1] ? -n1 : n1;
    mag2     = n2[W-1] ? -n2 : n2;
    mul_a    = (state_reg == FACT) ? acc_reg : n1;
    mul_b    = (state_reg == FACT) ? idx_reg : n2;
    product  = mul_a * mul_b;
    prod_top = product[2*W-1:W-1];
    mul_ovf  = !((&prod_top) || !(|prod_top));
  end

  impartire_secv #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (mag1),
    .divisor  (mag2),
    .quotient (quo),
    .remainder(rem),
    .done     (div_done)
  );

  // Next-state and result selection; fin marks a result to publish this edge.
  always_comb begin
    state_next = state_reg;
    mod_next   = mod_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    lim_next   = lim_reg;
    div_start  = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_code   = ERR_NONE;
    fin_val    = '0;
    case (state_reg)
      IDLE: begin
        if (valid_in) begin
          case (op)
            OP_ADD: begin
              fin = 1'b1; fin_val = sum;
              if (add_ovf) begin fin_err = 1'b1; fin_code = ERR_OVF; end
            end
            OP_SUB: begin
              fin = 1'b1; fin_val = diff;
              if (sub_ovf) begin fin_err = 1'b1; fin_code = ERR_OVF; end
            end
            OP_MUL: begin
              fin = 1'b1; fin_val = product[W-1:0];
              if (mul_ovf) begin fin_err = 1'b1; fin_code = ERR_OVF; end
            end
            OP_DIV, OP_MOD: begin
              if (n2 == '0) begin
                fin = 1'b1; fin_err = 1'b1; fin_code = ERR_DIV0;
              end else if (n1 == MIN_VAL && n2 == '1) begin
                // Quotient +2^(W-1) is unrepresentable; remainder is exactly 0.
                fin = 1'b1;
                if (op == OP_DIV) begin fin_err = 1'b1; fin_code = ERR_OVF; end
              end else begin
                div_start  = 1'b1;
                mod_next   = (op == OP_MOD);
                neg_q_next = n1[W-1] ^ n2[W-1];
                neg_r_next = n1[W-1];
                state_next = DIV;
              end
            end
            OP_FACT: begin
              if (n2[W-1]) begin
                fin = 1'b1; fin_err = 1'b1; fin_code = ERR_ILLEGAL;
              end else if (n2 < W'(2)) begin
                fin = 1'b1; fin_val = W'(1);
              end else begin
                acc_next   = W'(1);
                idx_next   = W'(2);
                lim_next   = n2;
                state_next = FACT;
              end
            end
            default: begin
              fin = 1'b1; fin_err = 1'b1; fin_code = ERR_ILLEGAL;
            end
          endcase
        end
      end
      DIV: begin
        if (div_done) begin
          fin = 1'b1;
          if (mod_reg) fin_val = neg_r_reg ? -rem : rem;
          else         fin_val = neg_q_reg ? -quo : quo;
          state_next = IDLE;
        end
      end
      FACT: begin
        if (mul_ovf) begin
          fin = 1'b1; fin_err = 1'b1; fin_code = ERR_OVF;
          state_next = IDLE;
        end else if (idx_reg == lim_reg) begin
          fin = 1'b1; fin_val = product[W-1:0];
          state_next = IDLE;
        end else begin
          acc_next = product[W-1:0];
          idx_next = idx_reg + W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    valid_next = fin;
    d_next     = fin ? (fin_err ? '0 : fin_val) : d_out;
    err_next   = fin ? fin_err : err;
    code_next  = fin ? fin_code : err_code;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operation context and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      lim_reg   <= '0;
      valid_out <= 1'b0;
      d_out     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      mod_reg   <= mod_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      lim_reg   <= lim_next;
      valid_out <= valid_next;
      d_out     <= d_next;
      err       <= err_next;
      err_code  <= code_next;
    end
  end

endmodule

// File: doc/alu_calc.md
# alu_calc

Parametrised, multi-mode arithmetic unit for the calculator datapath. It folds the separate sum, difference, product, divide and factorial blocks into one engine with a shared valid/ready handshake and a `W`-bit signed width. Single-cycle operations complete at acceptance. Division, modulo and factorial run as multi-cycle sequential operations. It sits between the keypad/operand register stage and the display formatter.

## Interface
- `W`, 28: operand and result width, two's complement signed, `W` >= 8.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `valid_in`  in  1: operation request. Accepted on a rising edge when `valid_in && ready`.
- `ready`  out  1: engine idle, able to accept.
- `op`  in  3: operation select.
  - 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 FACT.
  - 110 and 111 are illegal.
- `n1`  in  W: first operand (dividend / minuend); unused for FACT.
- `n2`  in  W: second operand (divisor / subtrahend / factorial argument).
- `valid_out`  out  1: one-cycle result pulse.
- `d_out`  out  W: result, held until the next result.
- `err`  out  1: result invalid, held with `d_out`.
- `err_code`  out  2: 00 none, 01 overflow, 10 divide by zero, 11 illegal op or negative factorial.

## Operation
- `op`, `n1` and `n2` are captured at acceptance. Later input changes are ignored until the next acceptance.
- `ready` = (state == IDLE). While busy, `valid_in` is ignored and nothing is queued.
- States: IDLE, DIV, FACT.
  - Results for ADD, SUB, MUL and all early errors are written at the acceptance edge; the state stays IDLE.
- ADD / SUB: full `W`-bit result.
  - Overflow when the operand signs meet the rule and the result sign differs: for ADD the operand signs are equal; for SUB they differ.
- MUL: 2W-bit signed product. Overflow if the upper W+1 bits are not all equal (the product does not fit `W` bits).
- DIV / MOD: truncating division, matching Verilog `/` and `%`.
  - Quotient is rounded toward zero. Remainder takes the dividend's sign.
  - `n2` == 0 gives `err_code` 10 at the acceptance edge.
  - `n1` = -2^(W-1) with `n2` = -1 gives overflow for DIV and remainder 0 for MOD.
  - Otherwise a restoring divider runs on magnitudes, one quotient bit per cycle for W cycles, then sign-corrects.
- FACT:
  - `n2` < 0 gives `err_code` 11 immediately.
  - `n2` of 0 or 1 gives `d_out` = 1 immediately.
  - Otherwise the accumulator starts at 1 and is multiplied by i = 2..`n2`, one multiply per cycle.
  - If a multiply overflows `W` bits, the run aborts with `err_code` 01.
- Illegal op: `err_code` 11 at the acceptance edge.
- On any error: `d_out` = 0, `err` = 1. On success: `err` = 0, `err_code` = 00.

## Timing
- Reset values: `valid_out` 0, `d_out` 0, `err` 0, `err_code` 00, state IDLE, hence `ready` 1.
- Acceptance edge is T0. Latency, measured to the edge at which `valid_out` is registered high:
  - ADD, SUB, MUL, illegal op, divide by zero, FACT with `n2` <= 1: T0. Throughput is one operation per cycle.
  - DIV / MOD: T0+W. `ready` is low from T0 to T0+W and rises at T0+W together with `valid_out`.
  - FACT with `n2` >= 2: T0+(`n2`-1). On overflow, the result is registered at the edge whose multiply overflows, i.e. T0+(i-1).
- A new request may be accepted in the cycle `valid_out` is high, since `ready` is already 1.
- `rst` during DIV or FACT aborts the operation asynchronously. No `valid_out` follows, and outputs take their reset values.
- `valid_out` is never high for two consecutive cycles from a single operation.

## Structure
- Package `alu_calc_pkg`:
  - op encoding constants
  - `err_code` constants
  - state enum (IDLE, DIV, FACT)
- Sub-module `impartire_secv`: W-bit unsigned restoring divider.
  - Inputs: start, dividend and divisor magnitudes.
  - Outputs: quotient, remainder, done.
  - Sign handling and the MIN / -1 case stay in `alu_calc`.
- The MUL overflow check is shared between MUL and the FACT step. Use one 2W-bit multiplier, muxed.

## Test plan
- ADD 99999900 + 120 -> `d_out` 100000020, `err` 0, `valid_out` at T0. ADD 134217727 + 1 -> `d_out` 0, `err_code` 01.
- DIV 412 / 6 -> 68 at T0+28 with `ready` low in between. MOD -168 % 25 -> -18. DIV -169 / 13 -> -13. DIV -2556 / 0 -> `err_code` 10 at T0.
- FACT 6 -> 720 at T0+5. FACT 11 -> 39916800 at T0+10. FACT 12 -> overflow `err_code` 01 at T0+11. FACT -5 -> `err_code` 11 at T0.
- Back-to-back: ADD 168+25, then SUB 168-3, then MUL 168*3 on consecutive edges -> 193, 165, 504 on three consecutive `valid_out` pulses.
- Busy handling: `valid_in` with ADD held during a DIV is ignored, giving no extra `valid_out`. `op` 111 -> `err_code` 11.
- Reset: assert `rst` at T0+10 of a DIV -> no `valid_out`, `ready` 1, `d_out` 0. A subsequent ADD 1 + 1 -> 2.
